// File: rtl/pong_match_controller.sv
// Pong match sequencer: serve countdown, rally, point hold and game over, plus both scores.
// Defining PONG_MATCH_PAUSE_EN adds a PAUSED state entered and left with pause_toggle.
module pong_match_controller #(
   parameter int unsigned WIN_SCORE          = 9,
   parameter int unsigned SERVE_DELAY_FRAMES = 60,
   parameter int unsigned POINT_HOLD_FRAMES  = 30,
   parameter int unsigned CNT_W              = 8
) (
   input  logic       CLOCK_25,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       point_p1,
   input  logic       point_p2,
   input  logic       pause_toggle,
   output logic       ball_run,
   output logic       ball_reset,
   output logic       serve_left,
   output logic [3:0] score_p1,
   output logic [3:0] score_p2,
   output logic [2:0] winner_color,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StServe    = 3'd1,
      StRally    = 3'd2,
      StPoint    = 3'd3,
      StGameOver = 3'd4,
      StPaused   = 3'd5
   } match_state_e;

   localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_DELAY_FRAMES);
   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(POINT_HOLD_FRAMES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [3:0]       WIN_LIM    = 4'(WIN_SCORE);

   match_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       score_p1_q, score_p1_d, score_p2_q, score_p2_d;
   logic [3:0]       p1_inc, p2_inc;
   logic             serve_left_q, serve_left_d;
   logic [2:0]       winner_q, winner_d;
   logic             ball_run_q, ball_run_d, ball_reset_q, ball_reset_d;

   assign p1_inc = score_p1_q + 4'd1;
   assign p2_inc = score_p2_q + 4'd1;

`ifndef PONG_MATCH_PAUSE_EN
   logic unused_pause_toggle;
   assign unused_pause_toggle = pause_toggle;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      score_p1_d   = score_p1_q;
      score_p2_d   = score_p2_q;
      serve_left_d = serve_left_q;
      winner_d     = winner_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StServe;
               cnt_d   = SERVE_LOAD;
            end
         end
         StServe: begin
            if (frame_tick) begin
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) state_d = StRally;
            end
         end
         StRally: begin
            // Simultaneous points are a replay: no score, serve side kept.
            if (point_p1 && point_p2) begin
               state_d = StPoint;
               cnt_d   = HOLD_LOAD;
            end else if (point_p1) begin
               score_p1_d   = p1_inc;
               serve_left_d = 1'b0;
               if (p1_inc == WIN_LIM) begin
                  state_d  = StGameOver;
                  winner_d = 3'b001;
               end else begin
                  state_d = StPoint;
                  cnt_d   = HOLD_LOAD;
               end
            end else if (point_p2) begin
               score_p2_d   = p2_inc;
               serve_left_d = 1'b1;
               if (p2_inc == WIN_LIM) begin
                  state_d  = StGameOver;
                  winner_d = 3'b100;
               end else begin
                  state_d = StPoint;
                  cnt_d   = HOLD_LOAD;
               end
`ifdef PONG_MATCH_PAUSE_EN
            end else if (pause_toggle) begin
               state_d = StPaused;
`endif
            end
         end
         StPoint: begin
            if (frame_tick) begin
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = StServe;
                  cnt_d   = SERVE_LOAD;
               end
            end
         end
         StGameOver: begin
            if (start) begin
               state_d      = StServe;
               cnt_d        = SERVE_LOAD;
               score_p1_d   = 4'd0;
               score_p2_d   = 4'd0;
               serve_left_d = 1'b0;
               winner_d     = 3'b000;
            end
         end
`ifdef PONG_MATCH_PAUSE_EN
         StPaused: begin
            if (pause_toggle) state_d = StRally;
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // Ball controls are decoded from the next state so they register alongside it.
   always_comb begin
      ball_run_d   = (state_d == StRally);
      ball_reset_d = !((state_d == StRally) || (state_d == StPaused));
   end

   always_ff @(posedge CLOCK_25 or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         score_p1_q   <= 4'd0;
         score_p2_q   <= 4'd0;
         serve_left_q <= 1'b0;
         winner_q     <= 3'b000;
         ball_run_q   <= 1'b0;
         ball_reset_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         score_p1_q   <= score_p1_d;
         score_p2_q   <= score_p2_d;
         serve_left_q <= serve_left_d;
         winner_q     <= winner_d;
         ball_run_q   <= ball_run_d;
         ball_reset_q <= ball_reset_d;
      end
   end

   assign ball_run     = ball_run_q;
   assign ball_reset   = ball_reset_q;
   assign serve_left   = serve_left_q;
   assign score_p1     = score_p1_q;
   assign score_p2     = score_p2_q;
   assign winner_color = winner_q;
   assign state        = state_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Bench for pong_match_controller: directed match script, per-cycle model compare, literal pins.
// Define PONG_MATCH_PAUSE_EN for both files to exercise the pause feature.
module tb_pong_match_controller;

   localparam int WS = 3;
   localparam int SD = 3;
   localparam int PH = 2;

   logic       CLOCK_25 = 1'b0;
   logic       reset;
   logic       frame_tick, start, point_p1, point_p2, pause_toggle;
   logic       ball_run, ball_reset, serve_left;
   logic [3:0] score_p1, score_p2;
   logic [2:0] winner_color, state;

   int checks = 0;
   int errors = 0;

   always #5 CLOCK_25 = ~CLOCK_25;

   pong_match_controller #(
      .WIN_SCORE(WS), .SERVE_DELAY_FRAMES(SD), .POINT_HOLD_FRAMES(PH), .CNT_W(8)
   ) dut (
      .CLOCK_25(CLOCK_25), .reset(reset), .frame_tick(frame_tick), .start(start),
      .point_p1(point_p1), .point_p2(point_p2), .pause_toggle(pause_toggle),
      .ball_run(ball_run), .ball_reset(ball_reset), .serve_left(serve_left),
      .score_p1(score_p1), .score_p2(score_p2), .winner_color(winner_color), .state(state)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase number, ticks elapsed in the current timed phase, plain integer scores.
   int m_phase, m_ticks, m_s1, m_s2;
   bit m_sl;

   always @(posedge CLOCK_25 or posedge reset) begin
      if (reset) begin
         m_phase <= 0; m_ticks <= 0; m_s1 <= 0; m_s2 <= 0; m_sl <= 0;
      end else if (m_phase == 0 && start) begin
         m_phase <= 1; m_ticks <= 0;
      end else if (m_phase == 4 && start) begin
         m_phase <= 1; m_ticks <= 0; m_s1 <= 0; m_s2 <= 0; m_sl <= 0;
      end else if (m_phase == 1 && frame_tick) begin
         if (m_ticks + 1 >= SD) m_phase <= 2;
         m_ticks <= m_ticks + 1;
      end else if (m_phase == 3 && frame_tick) begin
         if (m_ticks + 1 >= PH) begin m_phase <= 1; m_ticks <= 0; end
         else m_ticks <= m_ticks + 1;
      end else if (m_phase == 2 && (point_p1 || point_p2)) begin
         m_ticks <= 0;
         if (point_p1 && point_p2) m_phase <= 3;
         else if (point_p1) begin
            m_s1 <= m_s1 + 1; m_sl <= 0; m_phase <= (m_s1 + 1 >= WS) ? 4 : 3;
         end else begin
            m_s2 <= m_s2 + 1; m_sl <= 1; m_phase <= (m_s2 + 1 >= WS) ? 4 : 3;
         end
`ifdef PONG_MATCH_PAUSE_EN
      end else if (m_phase == 2 && pause_toggle) begin
         m_phase <= 5;
      end else if (m_phase == 5 && pause_toggle) begin
         m_phase <= 2;
`endif
      end
   end

   always @(negedge CLOCK_25) begin
      logic [2:0] exp_win;
      exp_win = (m_phase != 4) ? 3'b000 : (m_s1 >= WS) ? 3'b001 : 3'b100;
      check("cmp_state", {5'd0, state}, 8'(m_phase));
      check("cmp_ball_run", {7'd0, ball_run}, {7'd0, m_phase == 2});
      check("cmp_ball_reset", {7'd0, ball_reset}, {7'd0, !(m_phase == 2 || m_phase == 5)});
      check("cmp_serve_left", {7'd0, serve_left}, {7'd0, m_sl});
      check("cmp_score_p1", {4'd0, score_p1}, 8'(m_s1));
      check("cmp_score_p2", {4'd0, score_p2}, 8'(m_s2));
      check("cmp_winner", {5'd0, winner_color}, {5'd0, exp_win});
   end

   // Drive one cycle of inputs, hold through the next edge, then clear them 2 ns later.
   task automatic cyc(input logic t, input logic s, input logic p1, input logic p2,
                      input logic pt);
      frame_tick = t; start = s; point_p1 = p1; point_p2 = p2; pause_toggle = pt;
      @(posedge CLOCK_25);
      #2;
      frame_tick = 0; start = 0; point_p1 = 0; point_p2 = 0; pause_toggle = 0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b1;
      frame_tick = 0; start = 0; point_p1 = 0; point_p2 = 0; pause_toggle = 0;
      #7;
      check("rst_state", {5'd0, state}, 8'd0);
      check("rst_ball_reset", {7'd0, ball_reset}, 8'd1);
      check("rst_ball_run", {7'd0, ball_run}, 8'd0);
      #1 reset = 1'b0;

      cyc(0, 1, 0, 0, 0);
      check("start_state", {5'd0, state}, 8'd1);
      ticks(2);
      check("serve_2tick_run", {7'd0, ball_run}, 8'd0);
      check("serve_2tick_reset", {7'd0, ball_reset}, 8'd1);
      ticks(1);
      check("release_state", {5'd0, state}, 8'd2);
      check("release_run", {7'd0, ball_run}, 8'd1);

      cyc(0, 0, 1, 0, 0);
      check("p1_score", {4'd0, score_p1}, 8'd1);
      check("p1_state", {5'd0, state}, 8'd3);
      ticks(2);
      check("hold_done", {5'd0, state}, 8'd1);
      ticks(3);
      check("reserve_done", {5'd0, state}, 8'd2);

      cyc(0, 0, 0, 1, 0);
      check("p2_serve_left", {7'd0, serve_left}, 8'd1);
      ticks(5);
      cyc(0, 0, 0, 1, 0);
      check("p2_score2", {4'd0, score_p2}, 8'd2);
      ticks(5);
      cyc(0, 0, 1, 1, 0);
      check("replay_state", {5'd0, state}, 8'd3);
      check("replay_p1", {4'd0, score_p1}, 8'd1);
      check("replay_p2", {4'd0, score_p2}, 8'd2);
      ticks(5);
      cyc(0, 1, 0, 0, 0);
      check("start_in_rally", {5'd0, state}, 8'd2);

      cyc(1, 0, 0, 1, 0);
      check("win_state", {5'd0, state}, 8'd4);
      check("win_color", {5'd0, winner_color}, 8'd4);
      check("win_run", {7'd0, ball_run}, 8'd0);
      cyc(0, 0, 1, 0, 0);
      check("over_p1_held", {4'd0, score_p1}, 8'd1);
      cyc(0, 1, 0, 0, 0);
      check("restart_state", {5'd0, state}, 8'd1);
      check("restart_color", {5'd0, winner_color}, 8'd0);
      check("restart_p2", {4'd0, score_p2}, 8'd0);

      ticks(3);
      cyc(0, 0, 1, 0, 0);
      ticks(3);
      check("pre_reset_state", {5'd0, state}, 8'd1);
      #2 reset = 1'b1;
      #1;
      check("async_state", {5'd0, state}, 8'd0);
      check("async_p1", {4'd0, score_p1}, 8'd0);
      check("async_ball_reset", {7'd0, ball_reset}, 8'd1);
      #4 reset = 1'b0;
      @(posedge CLOCK_25);
      #2;

      cyc(0, 1, 0, 0, 0);
      ticks(3);
`ifdef PONG_MATCH_PAUSE_EN
      cyc(0, 0, 0, 0, 1);
      check("pause_state", {5'd0, state}, 8'd5);
      check("pause_run", {7'd0, ball_run}, 8'd0);
      check("pause_reset", {7'd0, ball_reset}, 8'd0);
      cyc(1, 1, 0, 1, 0);
      check("paused_point", {4'd0, score_p2}, 8'd0);
      check("paused_hold", {5'd0, state}, 8'd5);
      cyc(0, 0, 0, 0, 1);
      check("resume_state", {5'd0, state}, 8'd2);
      check("resume_run", {7'd0, ball_run}, 8'd1);
      cyc(0, 0, 1, 0, 1);
      check("point_beats_pause", {5'd0, state}, 8'd3);
`else
      cyc(0, 0, 0, 0, 1);
      check("no_pause_state", {5'd0, state}, 8'd2);
      check("no_pause_run", {7'd0, ball_run}, 8'd1);
`endif

      repeat (2) @(negedge CLOCK_25);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
